// File: rtl/alu_issue_if.sv
// Decode/issue stage bus: upstream instruction + operand inputs, downstream ALU entry.
interface alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_alu_in1;
  logic [XLEN-1:0] o_alu_in2;
  logic [4:0]      o_alu_control;
  logic [4:0]      o_rd;
  logic            o_illegal;

  modport slave (
    input  i_flush, i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
    output o_ready, o_valid, o_alu_in1, o_alu_in2, o_alu_control, o_rd, o_illegal
  );

  modport master (
    output i_flush, i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
    input  o_ready, o_valid, o_alu_in1, o_alu_in2, o_alu_control, o_rd, o_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes ALU opcode and operands, holds them in a
// one-entry valid/ready slot feeding the EX-stage ALU.
module alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  alu_issue_if.slave  bus
);

  localparam int unsigned SHW    = $clog2(XLEN);
  localparam int unsigned CTRL_W = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [CTRL_W-1:0] ALU_AND  = 5'b00001;
  localparam logic [CTRL_W-1:0] ALU_OR   = 5'b00010;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 5'b00011;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 5'b00100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 5'b00101;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 5'b00110;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 5'b10000;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 5'b10111;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 5'b11000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [4:0]        w_rd_field;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_s;
  logic [XLEN-1:0]   w_imm_u;
  logic [XLEN-1:0]   w_shamt_rs2;
  logic [XLEN-1:0]   w_shamt_imm;

  logic [XLEN-1:0]   w_in1;
  logic [XLEN-1:0]   w_in2;
  logic [CTRL_W-1:0] w_ctrl;
  logic [4:0]        w_rd;
  logic              w_ill;
  logic              w_load;

  logic              r_valid;
  logic [XLEN-1:0]   r_in1;
  logic [XLEN-1:0]   r_in2;
  logic [CTRL_W-1:0] r_ctrl;
  logic [4:0]        r_rd;
  logic              r_ill;

  assign w_opcode    = bus.i_instr[6:0];
  assign w_rd_field  = bus.i_instr[11:7];
  assign w_f3        = bus.i_instr[14:12];
  assign w_f7        = bus.i_instr[31:25];
  assign w_imm_i     = XLEN'($signed(bus.i_instr[31:20]));
  assign w_imm_s     = XLEN'($signed({bus.i_instr[31:25], bus.i_instr[11:7]}));
  assign w_imm_u     = XLEN'($signed({bus.i_instr[31:12], 12'b0}));
  // The ALU shifts by the whole of in2, so only the shamt bits may survive
  assign w_shamt_rs2 = XLEN'(bus.i_rs2_data[SHW-1:0]);
  assign w_shamt_imm = XLEN'(bus.i_instr[20 +: SHW]);

  // Instruction decode and operand select
  always_comb begin
    w_in1  = bus.i_rs1_data;
    w_in2  = bus.i_rs2_data;
    w_ctrl = ALU_ADD;
    w_rd   = w_rd_field;
    w_ill  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'b000:  w_ctrl = ALU_ADD;
            3'b001:  begin w_ctrl = ALU_SLL; w_in2 = w_shamt_rs2; end
            3'b010:  w_ctrl = ALU_SLT;
            3'b011:  w_ctrl = ALU_SLTU;
            3'b100:  w_ctrl = ALU_XOR;
            3'b101:  begin w_ctrl = ALU_SRL; w_in2 = w_shamt_rs2; end
            3'b110:  w_ctrl = ALU_OR;
            default: w_ctrl = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_ctrl = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_ctrl = ALU_SRA;
          w_in2  = w_shamt_rs2;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        w_in2 = w_imm_i;
        case (w_f3)
          3'b000: w_ctrl = ALU_ADD;
          3'b001: begin
            w_ctrl = ALU_SLL;
            w_in2  = w_shamt_imm;
            w_ill  = (w_f7 != F7_BASE);
          end
          3'b010: w_ctrl = ALU_SLT;
          3'b011: w_ctrl = ALU_SLTU;
          3'b100: w_ctrl = ALU_XOR;
          3'b101: begin
            w_ctrl = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_in2  = w_shamt_imm;
            w_ill  = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
          end
          3'b110:  w_ctrl = ALU_OR;
          default: w_ctrl = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        w_in1 = '0;
        w_in2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_in1 = bus.i_pc;
        w_in2 = w_imm_u;
      end
      OPC_LOAD: w_in2 = w_imm_i;
      OPC_STORE: begin
        w_in2 = w_imm_s;
        w_rd  = '0;
      end
      OPC_BRANCH: begin
        w_rd = '0;
        case (w_f3[2:1])
          2'b00:   w_ctrl = ALU_SUB;
          2'b01:   w_ill  = 1'b1;
          2'b10:   w_ctrl = ALU_SLT;
          default: w_ctrl = ALU_SLTU;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries still issue, but as a harmless ADD 0+0 with no writeback
    if (w_ill) begin
      w_in1  = '0;
      w_in2  = '0;
      w_ctrl = ALU_ADD;
      w_rd   = '0;
    end
  end

  assign bus.o_ready = !r_valid || bus.i_ready;
  assign w_load      = bus.i_valid && bus.o_ready && !bus.i_flush;

  // Entry valid: flush wins over load, drain clears when nothing replaces it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Entry payload: only written on load so it holds stable under backpressure
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in1  <= '0;
      r_in2  <= '0;
      r_ctrl <= ALU_ADD;
      r_rd   <= '0;
      r_ill  <= 1'b0;
    end else if (w_load) begin
      r_in1  <= w_in1;
      r_in2  <= w_in2;
      r_ctrl <= w_ctrl;
      r_rd   <= w_rd;
      r_ill  <= w_ill;
    end
  end

  assign bus.o_valid       = r_valid;
  assign bus.o_alu_in1     = r_in1;
  assign bus.o_alu_in2     = r_in2;
  assign bus.o_alu_control = r_ctrl;
  assign bus.o_rd          = r_rd;
  assign bus.o_illegal     = r_ill;

endmodule
